// File: rtl/delay_rx.sv
// delay_rx: circular-buffer receive FIFO with one-cycle pass-through, sticky overflow and sync flush.
module delay_rx #(
  parameter int delay_size = 8,
  parameter int cnt_size   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  valid_i,
  input  logic [delay_size-1:0] in_i,
  output logic                  next_o,
  output logic [delay_size-1:0] out_o,
  output logic                  ready_o,
  input  logic                  take_i,
  input  logic                  clear_i,
  output logic [cnt_size:0]     count_o,
  output logic                  overflow_o
);
  localparam logic [cnt_size:0] DEPTH = {1'b1, {cnt_size{1'b0}}};
  logic [delay_size-1:0] mem_q [2**cnt_size];
  logic [cnt_size-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [cnt_size:0]     count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  pop, push, drop;
  assign ready_o    = count_q != '0;
  assign next_o     = count_q < DEPTH;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign out_o      = ready_o ? mem_q[rd_q] : '0;
  always_comb begin
    pop     = take_i & ready_o & ~clear_i;
    push    = valid_i & ~clear_i & (next_o | pop);
    drop    = valid_i & ~clear_i & ~next_o & ~pop;
    wr_d    = clear_i ? '0 : push ? wr_q + 1'b1 : wr_q;
    rd_d    = clear_i ? '0 : pop ? rd_q + 1'b1 : rd_q;
    count_d = clear_i ? '0 : (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    ovf_d   = ~clear_i & (ovf_q | drop);
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage is unreset; only words behind a valid count are ever exposed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_i;
  end
endmodule

// File: doc/delay_rx.md
DELAY_RX -- requirements
Module: delay_rx

Interface
REQ-001 Parameter delay_size, default 8, SHALL set the data word width in bits.
REQ-002 Parameter cnt_size, default 4, SHALL set buffer depth DEPTH = 2**cnt_size words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-low reset (reset=0 clears state immediately).
REQ-005 valid  input  1  SHALL strobe an upstream word on in (the upstream ready/out side of delay).
REQ-006 in  input  delay_size  SHALL carry the upstream word, sampled when valid=1.
REQ-007 next  output  1  SHALL signal that the block can accept a word this cycle.
REQ-008 out  output  delay_size  SHALL present the oldest buffered word.
REQ-009 ready  output  1  SHALL signal that out holds a valid word.
REQ-010 take  input  1  SHALL be the downstream pop request; it is honoured only while ready=1.
REQ-011 clear  input  1  SHALL be a synchronous flush request.
REQ-012 count  output  cnt_size+1  SHALL report the number of buffered words, 0..DEPTH.
REQ-013 overflow  output  1  SHALL be a sticky flag for dropped words.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH words with write and read pointers of cnt_size bits each; the pointers wrap modulo DEPTH.
REQ-015 A pop SHALL occur on an edge where take=1, ready=1 and clear=0.
REQ-016 A push SHALL occur on an edge where valid=1, clear=0, and either count<DEPTH or a pop occurs on the same edge.
REQ-017 On a push, the block SHALL write in at the write pointer and advance the write pointer.
REQ-018 On a pop, the block SHALL advance the read pointer.
REQ-019 count SHALL increment by 1 on push only, decrement by 1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-020 next SHALL equal (count<DEPTH), derived from registered state only, with no combinational path from take.
REQ-021 ready SHALL equal (count!=0).
REQ-022 out SHALL equal the word at the read pointer while ready=1, and all zeros while ready=0.
REQ-023 Latency: a word pushed on edge N SHALL appear on out with ready=1 after edge N when the buffer was empty; pass-through is one cycle, with no combinational in-to-out path.
REQ-024 When valid=1, count=DEPTH, no pop and clear=0, the word SHALL be dropped, overflow SHALL set to 1, and the buffer contents and pointers SHALL stay unchanged.
REQ-025 take while ready=0 SHALL be ignored; no pointer moves and no error is flagged.
REQ-026 clear=1 SHALL, on the next edge, set both pointers and count to 0 and overflow to 0, overriding any simultaneous valid or take; the word presented with valid that cycle is discarded.
REQ-027 Words SHALL leave the block in strict arrival order, with no duplication and no loss except per REQ-024 and REQ-026.
REQ-028 Storage contents SHALL NOT need reset; outputs SHALL depend only on reset-cleared pointers and count.

Reset
REQ-029 While reset=0, the outputs SHALL be: next=1, ready=0, out=0, count=0, overflow=0; pointers SHALL be 0.
REQ-030 Deasserting reset SHALL take effect at the next clock edge, and valid=1 on that first edge SHALL be accepted.
REQ-031 Asserting reset mid-operation SHALL discard all buffered words and return the outputs immediately to REQ-029 values, without waiting for clk.

Verification (delay_size=8, cnt_size=2, DEPTH=4)
REQ-032 Single word: after reset, valid=1 and in=0xA5 for one cycle -> next cycle ready=1, out=0xA5, count=1; take=1 for one cycle -> ready=0, out=0x00, count=0.
REQ-033 Fill, overflow and wrap: push 0x01..0x05 on consecutive edges with take=0 -> count=4, next=0 after the 4th push, overflow=1 after the 5th; pop four times -> out=0x01,0x02,0x03,0x04; then push 0x06..0x09 (pointers wrapped) -> pops return 0x06..0x09.
REQ-034 Simultaneous push and pop at full: with the buffer holding 0x10..0x13, valid=1, in=0x14 and take=1 on the same edge -> count stays 4, overflow stays 0, subsequent pops return 0x11,0x12,0x13,0x14.
REQ-035 Clear priority: with count=3, assert clear=1 together with valid=1 (in=0x77) and take=1 -> next cycle count=0, ready=0, overflow=0, and 0x77 is never output.
REQ-036 Async reset: with count=2 and overflow=1, pull reset low between clock edges -> ready=0, count=0, overflow=0, next=1 before the next edge; release it and push 0x3C -> out=0x3C one cycle later.
REQ-037 Stream-through: drive the upstream delay block with 32 random words and take held at 1 -> output sequence equals input sequence, overflow=0 throughout.
